execute_writeback: RTL and testbench

Writeback stage directly downstream of the execute units (shift, ALU, etc.). It captures the destination register when an instruction is issued, waits for whichever execute unit reports completion, and then drives one registered register-file write. It also provides a busy/stall indication upstream and flags protocol errors: timeout, multiple completing units, and issue while busy.

---
 rtl/execute_writeback_if.sv | 35 +++
 rtl/execute_writeback.sv | 159 +++++++++++++++
 tb/tb_execute_writeback.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/execute_writeback_if.sv
// rtl/execute_writeback_if.sv - issue, execute-result and register-file write bundle for the writeback stage
interface execute_writeback_if #(
    parameter int NUM_UNITS = 4
);
    logic                    flush;
    logic                    read_valid;
    logic [4:0]              decode_rd;
    logic                    decode_rd_write;
    logic [NUM_UNITS-1:0]    exec_processing;
    logic [NUM_UNITS-1:0]    exec_valid;
    logic [NUM_UNITS*32-1:0] exec_rd_val;

    logic                    busy;
    logic                    rf_write_en;
    logic [4:0]              rf_write_addr;
    logic [31:0]             rf_write_val;
    logic                    retire;
    logic                    err_timeout;
    logic                    err_multi;
    logic                    err_issue_busy;

    modport master (
        output flush, read_valid, decode_rd, decode_rd_write,
               exec_processing, exec_valid, exec_rd_val,
        input  busy, rf_write_en, rf_write_addr, rf_write_val,
               retire, err_timeout, err_multi, err_issue_busy
    );

    modport slave (
        input  flush, read_valid, decode_rd, decode_rd_write,
               exec_processing, exec_valid, exec_rd_val,
        output busy, rf_write_en, rf_write_addr, rf_write_val,
               retire, err_timeout, err_multi, err_issue_busy
    );
endinterface

// File: rtl/execute_writeback.sv
// rtl/execute_writeback.sv - waits for an execute unit to finish and issues one registered register-file write
module execute_writeback #(
    parameter int NUM_UNITS = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    execute_writeback_if.slave wb
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_wr_q, rd_wr_d;

    logic             retire_q, retire_d;
    logic             wen_q, wen_d;
    logic [4:0]       addr_q, addr_d;
    logic [31:0]      val_q, val_d;

    logic             err_timeout_q, err_timeout_d;
    logic             err_multi_q, err_multi_d;
    logic             err_issue_busy_q, err_issue_busy_d;

    logic             in_wait;
    logic             issue;
    logic             hit;
    logic             multi;
    logic [31:0]      sel_val;
    logic [4:0]       tgt_rd;
    logic             tgt_wr;

    assign in_wait = (state_q == ST_WAIT);
    assign issue   = wb.read_valid && !in_wait;
    assign hit     = (|wb.exec_valid) && (issue || in_wait);
    // Clearing the lowest set bit leaves something only if two or more units reported.
    assign multi   = (wb.exec_valid & (wb.exec_valid - NUM_UNITS'(1))) != '0;

    // A single-cycle op retires against the instruction on the decode bus, not the latched copy.
    assign tgt_rd  = in_wait ? rd_q    : wb.decode_rd;
    assign tgt_wr  = in_wait ? rd_wr_q : wb.decode_rd_write;

    always_comb begin
        sel_val = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (wb.exec_valid[i]) begin
                sel_val = wb.exec_rd_val[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rd_d             = rd_q;
        rd_wr_d          = rd_wr_q;
        retire_d         = 1'b0;
        wen_d            = 1'b0;
        addr_d           = addr_q;
        val_d            = val_q;
        err_timeout_d    = err_timeout_q;
        err_multi_d      = err_multi_q;
        err_issue_busy_d = err_issue_busy_q;

        if (hit && multi) begin
            err_multi_d = 1'b1;
        end
        if (wb.read_valid && in_wait) begin
            err_issue_busy_d = 1'b1;
        end

        if (hit && !wb.flush) begin
            retire_d = 1'b1;
            if (tgt_wr && (tgt_rd != 5'd0)) begin
                wen_d  = 1'b1;
                addr_d = tgt_rd;
                val_d  = sel_val;
            end
        end

        if (wb.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue && !hit) begin
                        state_d = ST_WAIT;
                        rd_d    = wb.decode_rd;
                        rd_wr_d = wb.decode_rd_write;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT: begin
                    if (hit) begin
                        state_d = ST_IDLE;
                    end else if (|wb.exec_processing) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        // No unit has claimed the instruction for too long: abandon it without a write.
                        state_d       = ST_IDLE;
                        cnt_d         = '0;
                        err_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            rd_q             <= '0;
            rd_wr_q          <= 1'b0;
            retire_q         <= 1'b0;
            wen_q            <= 1'b0;
            addr_q           <= '0;
            val_q            <= '0;
            err_timeout_q    <= 1'b0;
            err_multi_q      <= 1'b0;
            err_issue_busy_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            rd_q             <= rd_d;
            rd_wr_q          <= rd_wr_d;
            retire_q         <= retire_d;
            wen_q            <= wen_d;
            addr_q           <= addr_d;
            val_q            <= val_d;
            err_timeout_q    <= err_timeout_d;
            err_multi_q      <= err_multi_d;
            err_issue_busy_q <= err_issue_busy_d;
        end
    end

    assign wb.busy           = in_wait;
    assign wb.retire         = retire_q;
    assign wb.rf_write_en    = wen_q;
    assign wb.rf_write_addr  = addr_q;
    assign wb.rf_write_val   = val_q;
    assign wb.err_timeout    = err_timeout_q;
    assign wb.err_multi      = err_multi_q;
    assign wb.err_issue_busy = err_issue_busy_q;

endmodule

// File: tb/tb_execute_writeback.sv
// tb/tb_execute_writeback.sv - directed bench with a pending-instruction reference model for execute_writeback
module tb_execute_writeback;

    localparam int NU  = 4;
    localparam int TMO = 4;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    execute_writeback_if #(.NUM_UNITS(NU)) bus ();

    execute_writeback #(.NUM_UNITS(NU), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding instruction, tracked by how long it has sat unclaimed.
    bit          m_pend;
    logic [4:0]  m_rd;
    bit          m_wr;
    int          m_idle;
    bit          x_retire, x_wen, x_et, x_em, x_eb;
    logic [4:0]  x_addr;
    logic [31:0] x_val;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pend = 0; m_rd = '0; m_wr = 0; m_idle = 0;
            x_retire = 0; x_wen = 0; x_addr = '0; x_val = '0;
            x_et = 0; x_em = 0; x_eb = 0;
        end else begin
            int   first;
            int   nval;
            bit   accept, done, wr_en;
            logic [4:0] wr_rd;
            first = -1;
            nval  = 0;
            for (int i = 0; i < NU; i++) begin
                if (bus.exec_valid[i]) begin
                    nval++;
                    if (first < 0) first = i;
                end
            end
            accept = !m_pend && bus.read_valid;
            done   = (accept || m_pend) && (nval > 0);
            if (bus.read_valid && m_pend) x_eb = 1;
            if (done && nval > 1) x_em = 1;
            wr_rd    = m_pend ? m_rd : bus.decode_rd;
            wr_en    = m_pend ? m_wr : bus.decode_rd_write;
            x_retire = done && !bus.flush;
            x_wen    = x_retire && wr_en && (wr_rd != 0);
            if (x_wen) begin
                x_addr = wr_rd;
                x_val  = bus.exec_rd_val[first*32 +: 32];
            end
            if (bus.flush) begin
                m_pend = 0;
                m_idle = 0;
            end else if (done) begin
                m_pend = 0;
            end else if (accept) begin
                m_pend = 1; m_rd = bus.decode_rd; m_wr = bus.decode_rd_write; m_idle = 0;
            end else if (m_pend) begin
                if (|bus.exec_processing) m_idle = 0;
                else if (m_idle == TMO - 1) begin
                    m_pend = 0; m_idle = 0; x_et = 1;
                end else m_idle++;
            end
        end
    end

    always @(negedge clk) begin
        check("busy",           32'(bus.busy),           32'(m_pend));
        check("retire",         32'(bus.retire),         32'(x_retire));
        check("rf_write_en",    32'(bus.rf_write_en),    32'(x_wen));
        check("rf_write_addr",  32'(bus.rf_write_addr),  32'(x_addr));
        check("rf_write_val",   bus.rf_write_val,        x_val);
        check("err_timeout",    32'(bus.err_timeout),    32'(x_et));
        check("err_multi",      32'(bus.err_multi),      32'(x_em));
        check("err_issue_busy", 32'(bus.err_issue_busy), 32'(x_eb));
    end

    task automatic clear_inputs();
        bus.flush = 0; bus.read_valid = 0; bus.decode_rd = '0; bus.decode_rd_write = 0;
        bus.exec_processing = '0; bus.exec_valid = '0; bus.exec_rd_val = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input bit wr);
        bus.read_valid = 1; bus.decode_rd = rd; bus.decode_rd_write = wr;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("rst_busy",   32'(bus.busy), 32'd0);
        check("rst_retire", 32'(bus.retire), 32'd0);
        check("rst_wen",    32'(bus.rf_write_en), 32'd0);
        check("rst_val",    bus.rf_write_val, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // SLLI rd=5: single-cycle result in the issue cycle
        issue(5'd5, 1); bus.exec_valid = 4'b0001; bus.exec_rd_val[31:0] = 32'h8;
        @(negedge clk);
        clear_inputs();
        check("slli_retire", 32'(bus.retire), 32'd1);
        check("slli_wen",    32'(bus.rf_write_en), 32'd1);
        check("slli_addr",   32'(bus.rf_write_addr), 32'd5);
        check("slli_val",    bus.rf_write_val, 32'h8);
        check("slli_busy",   32'(bus.busy), 32'd0);
        @(negedge clk);
        check("slli_one_pulse", 32'(bus.retire), 32'd0);

        // SRA rd=7: unit0 processes two cycles, then valid
        issue(5'd7, 1); bus.exec_processing = 4'b0001;
        @(negedge clk);
        clear_inputs(); bus.exec_processing = 4'b0001;
        check("sra_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        clear_inputs(); bus.exec_valid = 4'b0001; bus.exec_rd_val[31:0] = 32'hFFFFF800;
        check("sra_busy2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        clear_inputs();
        check("sra_wen",  32'(bus.rf_write_en), 32'd1);
        check("sra_addr", 32'(bus.rf_write_addr), 32'd7);
        check("sra_val",  bus.rf_write_val, 32'hFFFFF800);
        check("sra_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);

        // rd=0: retires without writing, write port holds its last value
        issue(5'd0, 1); bus.exec_valid = 4'b0010; bus.exec_rd_val[63:32] = 32'h1234;
        @(negedge clk);
        clear_inputs();
        check("rd0_retire", 32'(bus.retire), 32'd1);
        check("rd0_wen",    32'(bus.rf_write_en), 32'd0);
        check("rd0_hold",   bus.rf_write_val, 32'hFFFFF800);
        @(negedge clk);

        // flush while waiting; a later exec_valid must be ignored
        issue(5'd3, 1); bus.exec_processing = 4'b0001;
        @(negedge clk);
        clear_inputs(); bus.flush = 1; bus.exec_processing = 4'b0001;
        @(negedge clk);
        clear_inputs(); bus.exec_valid = 4'b0001; bus.exec_rd_val[31:0] = 32'h55;
        check("flush_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        clear_inputs();
        check("flush_retire", 32'(bus.retire), 32'd0);
        check("flush_wen",    32'(bus.rf_write_en), 32'd0);
        @(negedge clk);

        // a retire registered before a flush still appears
        issue(5'd4, 1); bus.exec_valid = 4'b0001; bus.exec_rd_val[31:0] = 32'h77;
        @(negedge clk);
        clear_inputs(); bus.flush = 1;
        check("old_retire", 32'(bus.retire), 32'd1);
        check("old_val",    bus.rf_write_val, 32'h77);
        @(negedge clk);
        clear_inputs();
        check("old_no_repeat", 32'(bus.retire), 32'd0);

        // multiple valid units plus issue while busy
        issue(5'd2, 1); bus.exec_processing = 4'b0110;
        @(negedge clk);
        clear_inputs(); issue(5'd13, 1); bus.exec_processing = 4'b0110;
        @(negedge clk);
        clear_inputs(); bus.exec_valid = 4'b0110;
        bus.exec_rd_val[63:32] = 32'hAA; bus.exec_rd_val[95:64] = 32'hBB;
        check("ib_flag", 32'(bus.err_issue_busy), 32'd1);
        check("ib_still_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        clear_inputs();
        check("multi_addr", 32'(bus.rf_write_addr), 32'd2);
        check("multi_val",  bus.rf_write_val, 32'hAA);
        check("multi_flag", 32'(bus.err_multi), 32'd1);
        @(negedge clk);

        // timeout: nothing processing, abort after TMO waiting cycles
        issue(5'd9, 1);
        @(negedge clk);
        clear_inputs();
        for (int c = 0; c < TMO; c++) begin
            check("tmo_busy", 32'(bus.busy), 32'd1);
            check("tmo_pending_err", 32'(bus.err_timeout), 32'd0);
            @(negedge clk);
        end
        check("tmo_flag",   32'(bus.err_timeout), 32'd1);
        check("tmo_idle",   32'(bus.busy), 32'd0);
        check("tmo_nowrite", 32'(bus.rf_write_en), 32'd0);
        check("tmo_addr_hold", 32'(bus.rf_write_addr), 32'd2);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
